// File: rtl/mux_2_pkg.sv
// mux_2 shared constants and helpers.
// Tree nodes live in one flat vector, one level after another.
package mux_2_pkg;

  localparam int WLOG_MIN = 1;
  localparam int WLOG_MAX = 8;

  // First node index of tree level k (level 0 is the data bus).
  function automatic int lvl_base(int w, int k);
    return 2 * w - ((2 * w) >> k);
  endfunction

endpackage

// File: rtl/mux_2_cell.sv
// mux_2 leaf: a single 2:1 selector cell.
// The tree in mux_2 is built out of these cells.
module mux2_cell (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_2.sv
// mux_2: 2^WLOG-to-1 bit selector built as a log-depth tree.
// It has true and complemented outputs and an optional output register.
module mux_2
  import mux_2_pkg::*;
#(
  parameter int WLOG = 3,
  parameter int REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<WLOG)-1:0]  a,
  input  logic [WLOG-1:0]       sel,
  output logic                  out,
  output logic                  out_neg
);

  localparam int W = 1 << WLOG;

  logic [2*W-2:0] node;
  logic           y;

  if (WLOG < WLOG_MIN || WLOG > WLOG_MAX) begin : g_bad_wlog
    $error("mux_2: WLOG out of range 1..8");
  end

  assign node[W-1:0] = a;

  for (genvar k = 0; k < WLOG; k++) begin : g_lvl
    localparam int IB = lvl_base(W, k);
    localparam int OB = lvl_base(W, k + 1);
    for (genvar j = 0; j < (W >> (k + 1)); j++) begin : g_pos
      mux2_cell u_cell (
        .d0 (node[IB+2*j]),
        .d1 (node[IB+2*j+1]),
        .s  (sel[k]),
        .y  (node[OB+j])
      );
    end
  end

  assign y = node[2*W-2];

  // Both outputs come from the one root node so they never disagree.
  if (REG != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out     <= 1'b0;
        out_neg <= 1'b1;
      end else begin
        out     <= y;
        out_neg <= ~y;
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign out        = y;
    assign out_neg    = ~y;
  end

endmodule

// File: tb/tb_mux_2.sv
// tb_mux_2: randomized self-checking bench for mux_2.
// Expected bits come from shift-and-mask arithmetic on the bus.
module tb_mux_2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a3;
  logic [2:0]  s3;
  logic [1:0]  a1;
  logic [0:0]  s1;
  logic [3:0]  a2;
  logic [1:0]  s2;
  logic [15:0] a4;
  logic [3:0]  s4;

  logic o_c3, n_c3, o_r3, n_r3;
  logic o_c1, n_c1, o_r1, n_r1;
  logic o_c2, n_c2, o_r2, n_r2;
  logic o_c4, n_c4, o_r4, n_r4;

  int n_cmp = 0;
  int n_err = 0;

  mux_2 #(.WLOG(3), .REG(0)) u_c3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .sel(s3),
    .out(o_c3), .out_neg(n_c3));
  mux_2 #(.WLOG(3), .REG(1)) u_r3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .sel(s3),
    .out(o_r3), .out_neg(n_r3));
  mux_2 #(.WLOG(1), .REG(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .sel(s1),
    .out(o_c1), .out_neg(n_c1));
  mux_2 #(.WLOG(1), .REG(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .sel(s1),
    .out(o_r1), .out_neg(n_r1));
  mux_2 #(.WLOG(2), .REG(0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .sel(s2),
    .out(o_c2), .out_neg(n_c2));
  mux_2 #(.WLOG(2), .REG(1)) u_r2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .sel(s2),
    .out(o_r2), .out_neg(n_r2));
  mux_2 #(.WLOG(4), .REG(0)) u_c4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .sel(s4),
    .out(o_c4), .out_neg(n_c4));
  mux_2 #(.WLOG(4), .REG(1)) u_r4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .sel(s4),
    .out(o_r4), .out_neg(n_r4));

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic [15:0] v,
                                input int i);
    return ((v >> i) & 16'd1) != 16'd0;
  endfunction

  logic e1, e2, e3, e4;
  logic [15:0] v;

  initial begin
    rst_n = 1'b1;
    a3 = '0; s3 = '0;
    a1 = '0; s1 = '0;
    a2 = '0; s2 = '0;
    a4 = '0; s4 = '0;

    // Combinational: sel=3, sweep a over 0..16 (bus is 8 bits).
    s3 = 3'd3;
    for (int i = 0; i <= 16; i++) begin
      v  = 16'(i);
      a3 = v[7:0];
      #1;
      e3 = (i >= 8 && i <= 15);
      chk("sweep_a", o_c3, e3);
      chk("sweep_a_neg", n_c3, ~e3);
    end

    // Fixed pattern A5, walk sel.
    a3 = 8'hA5;
    for (int s = 0; s < 8; s++) begin
      s3 = 3'(s);
      #1;
      e3 = pick(16'h00A5, s);
      chk("a5", o_c3, e3);
      chk("a5_neg", n_c3, ~e3);
    end

    // Walking one.
    for (int i = 0; i < 8; i++) begin
      v  = 16'd1 << i;
      a3 = v[7:0];
      for (int s = 0; s < 8; s++) begin
        s3 = 3'(s);
        #1;
        chk("walk1", o_c3, s == i);
      end
    end

    // X on unselected bits must not leak through.
    a3 = 8'bxxxx_1xxx;
    s3 = 3'd3;
    #1;
    chk("x_unsel", o_c3, 1'b1);
    chk("x_unsel_neg", n_c3, 1'b0);
    a3 = 8'bxxxx_xx0x;
    s3 = 3'd1;
    #1;
    chk("x_unsel0", o_c3, 1'b0);

    // Registered: hold reset for two cycles with all-ones data.
    @(negedge clk);
    rst_n = 1'b0;
    a3 = 8'hFF;
    s3 = 3'd7;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rst_out", o_r3, 1'b0);
      chk("rst_neg", n_r3, 1'b1);
      chk("rst_out_w4", o_r4, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_out", o_r3, 1'b1);
    chk("rel_neg", n_r3, 1'b0);

    // Mid-stream reset with sel=0.
    @(negedge clk);
    s3 = 3'd0;
    @(posedge clk);
    #1;
    chk("mid_pre", o_r3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst", o_r3, 1'b0);
    chk("mid_rst_neg", n_r3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel", o_r3, 1'b1);
    chk("mid_rel_neg", n_r3, 1'b0);

    // Random sweep across widths, comb and one-cycle-late registered.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a1 = 2'($urandom);
      s1 = 1'($urandom);
      a2 = 4'($urandom);
      s2 = 2'($urandom);
      a3 = 8'($urandom);
      s3 = 3'($urandom);
      a4 = 16'($urandom);
      s4 = 4'($urandom);
      #1;
      e1 = pick(16'(a1), int'(s1));
      e2 = pick(16'(a2), int'(s2));
      e3 = pick(16'(a3), int'(s3));
      e4 = pick(a4, int'(s4));
      chk("rnd_c1", o_c1, e1);
      chk("rnd_c1_neg", n_c1, ~e1);
      chk("rnd_c2", o_c2, e2);
      chk("rnd_c2_neg", n_c2, ~e2);
      chk("rnd_c3", o_c3, e3);
      chk("rnd_c4", o_c4, e4);
      chk("rnd_c4_neg", n_c4, ~e4);
      @(posedge clk);
      #1;
      chk("rnd_r1", o_r1, e1);
      chk("rnd_r1_neg", n_r1, ~e1);
      chk("rnd_r2", o_r2, e2);
      chk("rnd_r2_neg", n_r2, ~e2);
      chk("rnd_r3", o_r3, e3);
      chk("rnd_r4", o_r4, e4);
      chk("rnd_r4_neg", n_r4, ~e4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
